threefish1024_round_engine: RTL and testbench

//  Self-sequencing Threefish-1024 encryption engine, successor to the externally driven core

---
 rtl/threefish1024_round_engine.sv | 202 ++++++++++++++++++++
 tb/tb_threefish1024_round_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threefish1024_round_engine.sv
// Threefish-1024 encryption engine with internal round/subkey sequencing,
// LANES parallel MIX units, valid/ready handshakes and optional UBI feed-forward.
module threefish1024_round_engine #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned ROUNDS = 80
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [1023:0] key_i,
  input  logic [127:0]  tweak_i,
  input  logic [1023:0] block_i,
  input  logic          feed_forward_i,
  input  logic [383:0]  rot_table_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [1023:0] result_o
);

  localparam int unsigned WW       = 64;
  localparam int unsigned NW       = 16;
  localparam int unsigned CYC      = 8 / LANES;
  localparam int unsigned CW       = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int unsigned INJ_LAST = ROUNDS / 4;
  localparam int unsigned SW       = $clog2(INJ_LAST + 1);
  localparam logic [WW-1:0] KS_PARITY = 64'h1BD11BDAA9FC1A22;
  localparam logic [3:0] PERM [NW] = '{4'd0, 4'd9, 4'd2, 4'd13, 4'd6, 4'd11, 4'd4, 4'd15,
                                       4'd10, 4'd7, 4'd12, 4'd3, 4'd14, 4'd5, 4'd8, 4'd1};

  typedef enum logic [1:0] {ST_IDLE, ST_INJECT, ST_ROUND, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] v_q [NW];
  logic [WW-1:0] f_q [NW];
  logic [WW-1:0] k_q [NW+1];
  logic [WW-1:0] t_q [3];
  logic [1023:0] blk_q;
  logic          ff_q;
  logic [SW-1:0] s_q;
  logic [2:0]    d_q;
  logic [CW-1:0] c_q;

  logic          accept;
  logic          s_last;
  logic          c_last;
  logic [WW-1:0] kx;
  logic [WW-1:0] inj [NW];
  logic [1023:0] inj_flat;
  logic [4:0]    ki;
  logic [1:0]    ts0, ts1;
  logic [WW-1:0] f_d [NW];
  logic [WW-1:0] perm [NW];
  logic [2:0]    pj;
  logic [8:0]    rb;
  logic [WW-1:0] y0;
  logic          in_ready_d;
  logic          out_valid_d;
  logic [1023:0] result_d;

  function automatic logic [WW-1:0] rotl64(input logic [WW-1:0] x, input logic [5:0] r);
    logic [2*WW-1:0] dbl;
    dbl = {x, x} << r;
    return dbl[2*WW-1:WW];
  endfunction

  assign accept = in_valid_i && in_ready_o && (state_q == ST_IDLE);
  assign s_last = (s_q == SW'(INJ_LAST));
  assign c_last = (c_q == CW'(CYC - 1));

  // Extended key word k16 from the incoming key
  always_comb begin
    kx = KS_PARITY;
    for (int unsigned i = 0; i < NW; i++) kx = kx ^ key_i[WW*i +: WW];
  end

  // Subkey injection of schedule entry s into the state
  always_comb begin
    ki  = '0;
    ts0 = 2'(32'(s_q) % 32'd3);
    ts1 = 2'((32'(s_q) + 32'd1) % 32'd3);
    for (int unsigned i = 0; i < NW; i++) begin
      ki     = 5'((32'(s_q) + i) % 32'd17);
      inj[i] = v_q[i] + k_q[ki];
    end
    inj[13] = inj[13] + t_q[ts0];
    inj[14] = inj[14] + t_q[ts1];
    inj[15] = inj[15] + WW'(s_q);
    for (int unsigned i = 0; i < NW; i++) inj_flat[WW*i +: WW] = inj[i];
  end

  // MIX lanes for this cycle's pairs, merged into staged outputs, then permuted
  always_comb begin
    f_d = f_q;
    pj  = '0;
    rb  = '0;
    y0  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      pj = 3'(32'(c_q) * LANES + l);
      rb = 9'({d_q, pj}) * 9'd6;
      y0 = v_q[{pj, 1'b0}] + v_q[{pj, 1'b1}];
      f_d[{pj, 1'b0}] = y0;
      f_d[{pj, 1'b1}] = rotl64(v_q[{pj, 1'b1}], rot_table_i[rb +: 6]) ^ y0;
    end
    for (int unsigned i = 0; i < NW; i++) perm[i] = f_d[PERM[i]];
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_INJECT;
      ST_INJECT: state_d = s_last ? ST_DONE : ST_ROUND;
      ST_ROUND:  if (c_last && (d_q[1:0] == 2'd3)) state_d = ST_INJECT;
      ST_DONE:   if (out_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output next values; result captured as the final injection completes
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = out_valid_o;
    result_d    = result_o;
    if ((state_q == ST_INJECT) && s_last) begin
      out_valid_d = 1'b1;
      result_d    = ff_q ? (inj_flat ^ blk_q) : inj_flat;
    end else if ((state_q == ST_DONE) && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
    end else begin
      in_ready_o  <= in_ready_d;
      out_valid_o <= out_valid_d;
      result_o    <= result_d;
    end
  end

  // Job state: key schedule, cipher state, staging and counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < NW; i++) begin
        v_q[i] <= '0;
        f_q[i] <= '0;
      end
      for (int unsigned i = 0; i <= NW; i++) k_q[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) t_q[i] <= '0;
      blk_q <= '0;
      ff_q  <= 1'b0;
      s_q   <= '0;
      d_q   <= '0;
      c_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          for (int unsigned i = 0; i < NW; i++) begin
            v_q[i] <= block_i[WW*i +: WW];
            k_q[i] <= key_i[WW*i +: WW];
          end
          k_q[NW] <= kx;
          t_q[0]  <= tweak_i[63:0];
          t_q[1]  <= tweak_i[127:64];
          t_q[2]  <= tweak_i[63:0] ^ tweak_i[127:64];
          blk_q   <= block_i;
          ff_q    <= feed_forward_i;
          s_q     <= '0;
          d_q     <= '0;
          c_q     <= '0;
        end
        ST_INJECT: begin
          for (int unsigned i = 0; i < NW; i++) v_q[i] <= inj[i];
          if (!s_last) s_q <= s_q + SW'(1);
        end
        ST_ROUND: begin
          if (c_last) begin
            for (int unsigned i = 0; i < NW; i++) v_q[i] <= perm[i];
            d_q <= d_q + 3'd1;
            c_q <= '0;
          end else begin
            for (int unsigned i = 0; i < NW; i++) f_q[i] <= f_d[i];
            c_q <= c_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_threefish1024_round_engine.sv
// Bench for threefish1024_round_engine: an 80-round LANES=2 instance and a
// 4-round LANES=4 instance, checked against a word-level Threefish model.
module tb_threefish1024_round_engine;

  localparam int LAT_MAIN  = 80/4 + 1 + 80*8/2;
  localparam int LAT_SMALL = 4/4 + 1 + 4*8/4;
  localparam int PERM_TB [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

  typedef struct {
    logic [1023:0] key;
    logic [127:0]  tweak;
    logic [1023:0] blk;
    bit            ff;
    logic [1023:0] exp;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [1023:0] key;
  logic [127:0]  tweak;
  logic [1023:0] blk;
  logic          ff;
  logic [383:0]  rot;
  logic          m_vld, m_rdy, m_ov, m_ordy;
  logic [1023:0] m_res;
  logic          s_vld, s_rdy, s_ov, s_ordy;
  logic [1023:0] s_res;

  int n_vec = 0;
  int n_bad = 0;

  threefish1024_round_engine #(.LANES(2), .ROUNDS(80)) u_main (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(m_vld), .in_ready_o(m_rdy),
    .key_i(key), .tweak_i(tweak), .block_i(blk), .feed_forward_i(ff),
    .rot_table_i(rot), .out_valid_o(m_ov), .out_ready_i(m_ordy), .result_o(m_res)
  );

  threefish1024_round_engine #(.LANES(4), .ROUNDS(4)) u_small (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(s_vld), .in_ready_o(s_rdy),
    .key_i(key), .tweak_i(tweak), .block_i(blk), .feed_forward_i(ff),
    .rot_table_i(rot), .out_valid_o(s_ov), .out_ready_i(s_ordy), .result_o(s_res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Textbook Threefish-1024: inject every 4 rounds, MIX all pairs, permute
  function automatic logic [1023:0] tf_model(input logic [1023:0] k_in, input logic [127:0] tw,
                                             input logic [1023:0] pt, input bit ffw, input int rounds);
    logic [63:0] k [17];
    logic [63:0] t [3];
    logic [63:0] v [16];
    logic [63:0] f [16];
    logic [63:0] a, b;
    logic [1023:0] out;
    int n, s;
    k[16] = 64'h1BD11BDAA9FC1A22;
    for (int i = 0; i < 16; i++) begin
      k[i]  = k_in[64*i +: 64];
      k[16] = k[16] ^ k[i];
      v[i]  = pt[64*i +: 64];
    end
    t[0] = tw[63:0];
    t[1] = tw[127:64];
    t[2] = t[0] ^ t[1];
    for (int r = 0; r <= rounds; r++) begin
      if (r % 4 == 0) begin
        s = r / 4;
        for (int i = 0; i < 16; i++) v[i] = v[i] + k[(s + i) % 17];
        v[13] = v[13] + t[s % 3];
        v[14] = v[14] + t[(s + 1) % 3];
        v[15] = v[15] + 64'(s);
      end
      if (r == rounds) break;
      for (int j = 0; j < 8; j++) begin
        a = v[2*j];
        b = v[2*j+1];
        n = int'(rot[6*(8*(r % 8) + j) +: 6]);
        f[2*j]   = a + b;
        f[2*j+1] = ((b << n) | (b >> (64 - n))) ^ (a + b);
      end
      for (int i = 0; i < 16; i++) v[i] = f[PERM_TB[i]];
    end
    for (int i = 0; i < 16; i++) out[64*i +: 64] = ffw ? (v[i] ^ pt[64*i +: 64]) : v[i];
    return out;
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      w = 0;
      for (int i = 15; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) w = i;
      $display("FAIL %s: word %0d got %h want %h", name, w, act[64*w +: 64], exp[64*w +: 64]);
    end
  endtask

  // Present a job and return at the negedge just after the accept edge
  task automatic start_job(input bit sel, input logic [1023:0] k, input logic [127:0] t,
                           input logic [1023:0] b, input bit f);
    bit ok;
    @(negedge clk);
    key = k; tweak = t; blk = b; ff = f;
    if (sel) s_vld = 1'b1; else m_vld = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? s_rdy : m_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_vld = 1'b0;
    m_vld = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, want 1");
    end
  endtask

  // Cycles from the accept edge until out_valid is seen (bounded)
  task automatic wait_out(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? s_ov : m_ov) && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_job(input bit sel, input logic [1023:0] k, input logic [127:0] t,
                         input logic [1023:0] b, input bit f,
                         output logic [1023:0] r, output int lat);
    start_job(sel, k, t, b, f);
    wait_out(sel, lat);
    r = sel ? s_res : m_res;
    if (sel) s_ordy = 1'b1; else m_ordy = 1'b1;
    @(negedge clk);
    s_ordy = 1'b0;
    m_ordy = 1'b0;
  endtask

  vec_t          tbl [4];
  logic [1023:0] r, e, ja, jb;
  logic [127:0]  jt;
  int            lat;
  logic [1023:0] exp_q [$];

  initial begin
    int cyc, acc, got, hs_at;
    bit chg;
    rst_n = 1'b0;
    m_vld = 1'b0; m_ordy = 1'b0; s_vld = 1'b0; s_ordy = 1'b0;
    key = '0; tweak = '0; blk = '0; ff = 1'b0;
    for (int i = 0; i < 64; i++) rot[6*i +: 6] = 6'($urandom_range(0, 63));
    rot[5:0]   = 6'd0;
    rot[53:48] = 6'd63;

    tbl[0] = '{key: '0, tweak: '0, blk: '0, ff: 1'b0, exp: {64'h1BD11BDAA9FC1A23, 960'h0}};
    tbl[1] = '{key: '0, tweak: '0, blk: '0, ff: 1'b1, exp: {64'h1BD11BDAA9FC1A23, 960'h0}};
    tbl[2] = '{key: '0, tweak: '0, blk: 1024'h1, ff: 1'b1, exp: '0};
    tbl[2].exp = tf_model(tbl[2].key, tbl[2].tweak, tbl[2].blk, tbl[2].ff, 4);
    tbl[3] = '{key: rand1024(), tweak: {$urandom, $urandom, $urandom, $urandom},
               blk: rand1024(), ff: 1'b0, exp: '0};
    tbl[3].exp = tf_model(tbl[3].key, tbl[3].tweak, tbl[3].blk, tbl[3].ff, 4);

    // Reset values while reset is held
    #3;
    chk("rst_in_ready_main", 1024'(m_rdy), 1024'(0));
    chk("rst_out_valid_main", 1024'(m_ov), 1024'(0));
    chk("rst_result_main", m_res, '0);
    chk("rst_out_valid_small", 1024'(s_ov), 1024'(0));
    chk("rst_result_small", s_res, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready_main", 1024'(m_rdy), 1024'(1));
    chk("post_rst_in_ready_small", 1024'(s_rdy), 1024'(1));

    // Short-schedule table on the 4-round instance
    for (int i = 0; i < 4; i++) begin
      run_job(1'b1, tbl[i].key, tbl[i].tweak, tbl[i].blk, tbl[i].ff, r, lat);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), 1024'(lat), 1024'(LAT_SMALL));
    end

    // Random full-length jobs
    for (int i = 0; i < 4; i++) begin
      ja = rand1024();
      jb = rand1024();
      jt = {$urandom, $urandom, $urandom, $urandom};
      e  = tf_model(ja, jt, jb, i[0], 80);
      run_job(1'b0, ja, jt, jb, i[0], r, lat);
      chk($sformatf("rand%0d_result", i), r, e);
      chk($sformatf("rand%0d_latency", i), 1024'(lat), 1024'(LAT_MAIN));
    end

    // Output stall of 50 cycles with a competing request on the input
    ja = rand1024(); jb = rand1024(); jt = {$urandom, $urandom, $urandom, $urandom};
    e  = tf_model(ja, jt, jb, 1'b1, 80);
    start_job(1'b0, ja, jt, jb, 1'b1);
    wait_out(1'b0, lat);
    chk("stall_latency", 1024'(lat), 1024'(LAT_MAIN));
    key = rand1024(); blk = rand1024(); ff = 1'b0;
    m_vld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 1024'(m_ov), 1024'(1));
      chk("stall_result", m_res, e);
      chk("stall_in_ready", 1024'(m_rdy), 1024'(0));
    end
    m_vld = 1'b0;
    m_ordy = 1'b1;
    @(negedge clk);
    m_ordy = 1'b0;
    chk("stall_release_in_ready", 1024'(m_rdy), 1024'(1));
    chk("stall_release_out_valid", 1024'(m_ov), 1024'(0));
    repeat (3) @(negedge clk);
    chk("stall_no_stray_job", 1024'(m_rdy), 1024'(1));

    // Reset in the middle of a job, then a fresh job
    start_job(1'b0, rand1024(), {$urandom, $urandom, $urandom, $urandom}, rand1024(), 1'b0);
    repeat (99) @(negedge clk);
    chk("midjob_out_valid", 1024'(m_ov), 1024'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 1024'(m_ov), 1024'(0));
    chk("midrst_result", m_res, '0);
    chk("midrst_in_ready", 1024'(m_rdy), 1024'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_after", 1024'(m_rdy), 1024'(1));
    ja = rand1024(); jb = rand1024(); jt = {$urandom, $urandom, $urandom, $urandom};
    e  = tf_model(ja, jt, jb, 1'b1, 80);
    run_job(1'b0, ja, jt, jb, 1'b1, r, lat);
    chk("after_rst_result", r, e);
    chk("after_rst_latency", 1024'(lat), 1024'(LAT_MAIN));

    // Back-to-back jobs with both handshakes held high
    @(negedge clk);
    key = rand1024(); blk = rand1024(); tweak = {$urandom, $urandom, $urandom, $urandom}; ff = 1'b0;
    m_vld = 1'b1;
    m_ordy = 1'b1;
    cyc = 0; acc = 0; got = 0; hs_at = -10; chg = 1'b0;
    while (got < 3 && cyc < 3000) begin
      if (m_ov && m_ordy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL b2b_extra_result: got unexpected result, want none");
        end else begin
          chk($sformatf("b2b%0d_result", got), m_res, exp_q.pop_front());
        end
        got++;
        hs_at = cyc;
      end
      if (m_vld && m_rdy) begin
        exp_q.push_back(tf_model(key, tweak, blk, ff, 80));
        if (acc > 0) chk($sformatf("b2b%0d_accept_gap", acc), 1024'(cyc), 1024'(hs_at + 1));
        acc++;
        chg = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (chg) begin
        chg = 1'b0;
        if (acc < 3) begin
          key = rand1024(); blk = rand1024(); tweak = {$urandom, $urandom, $urandom, $urandom};
          ff = ~ff;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
    chk("b2b_results_seen", 1024'(got), 1024'(3));
    chk("b2b_pending", 1024'(exp_q.size()), 1024'(0));
    repeat (5) @(negedge clk);
    chk("b2b_no_duplicate", 1024'(m_ov), 1024'(0));
    m_ordy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
